// File: rtl/uart_flash_pkg.sv
// Shared definitions for the UART frame sender: FSM states,
// byte width and the default address width.
package uart_flash_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_TX,
        FINISH
    } stateT;

endpackage

// File: rtl/uart_frame_sender.sv
// Reads a frame of data_length bytes from RAM and hands them one by one
// to a UART transmitter using a tx_valid pulse and the tx_busy level.
// Ports: clk, rst_n (async, active-low), start, abort, data_length,
// ram_addr/ram_rd_en/ram_data (1-cycle read RAM), tx_data/tx_valid/tx_busy
// (UART side), busy, done.
// Build option: UART_FRAME_CHECKSUM_EN appends a mod-256 checksum byte.
module uart_frame_sender
    import uart_flash_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] data_length,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [BYTE_W-1:0] ram_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done
);

    stateT             state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] lenReg;
    logic [ADDR_W:0]   nextIndex;
    logic              lastByte;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] checksum;
    logic              csumSent;
`endif

    // One extra bit so index+1 never wraps at the maximum length.
    assign nextIndex = {1'b0, index} + {{ADDR_W{1'b0}}, 1'b1};
    assign lastByte  = (nextIndex >= {1'b0, lenReg});

    // busy is a registered flag that stays high through the done cycle,
    // so a start arriving while done is still showing is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            lenReg    <= '0;
            ram_addr  <= '0;
            ram_rd_en <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            checksum  <= '0;
            csumSent  <= 1'b0;
`endif
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            ram_rd_en <= 1'b0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !busy) begin
                        lenReg <= data_length;
                        index  <= '0;
                        busy   <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                        checksum <= '0;
                        csumSent <= 1'b0;
`endif
                        if (data_length == '0) begin
                            state <= FINISH;
                        end else begin
                            state     <= READ;
                            ram_rd_en <= 1'b1;
                            ram_addr  <= '0;
                        end
                    end
                end
                READ: begin
                    ram_rd_en <= 1'b0;
                    state     <= LOAD;
                end
                LOAD: begin
                    tx_data  <= ram_data;
                    tx_valid <= 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    checksum <= checksum + ram_data;
`endif
                    state    <= SEND;
                end
                SEND: begin
                    tx_valid <= 1'b0;
                    state    <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (!tx_busy) begin
                        index <= nextIndex[ADDR_W-1:0];
                        if (!lastByte) begin
                            state     <= READ;
                            ram_rd_en <= 1'b1;
                            ram_addr  <= nextIndex[ADDR_W-1:0];
                        end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                            if (!csumSent) begin
                                tx_data  <= checksum;
                                tx_valid <= 1'b1;
                                csumSent <= 1'b1;
                                state    <= SEND;
                            end else begin
                                state <= FINISH;
                            end
`else
                            state <= FINISH;
`endif
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender with a RAM model and a UART
// model; frame vectors come from a table, corner cases are hand-written.
module tb_uart_frame_sender;

`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_length = '0;
    logic [7:0] ram_addr;
    logic       ram_rd_en;
    logic [7:0] ram_data = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic       done;

    uart_frame_sender #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .data_length(data_length), .ram_addr(ram_addr),
        .ram_rd_en(ram_rd_en), .ram_data(ram_data), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_busy(tx_busy), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [256];
    always @(posedge clk) if (ram_rd_en) ram_data <= mem[ram_addr];

    int uartLat = 10;
    int ucnt = 0;
    bit uartHold = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            tx_busy = 1'b0;
            ucnt = 0;
        end else if (tx_valid && !uartHold) begin
            tx_busy = 1'b1;
            ucnt = uartLat;
        end else if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) tx_busy = 1'b0;
        end
    end

    logic [7:0] txQ [$];
    logic [7:0] rdQ [$];
    int firstRd, firstTx, doneCnt, doneCyc, busyCyc, startCyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_rd_en) begin
                rdQ.push_back(ram_addr);
                if (firstRd < 0) firstRd = cyc;
            end
            if (tx_valid) begin
                txQ.push_back(tx_data);
                if (firstTx < 0) firstTx = cyc;
            end
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (busy) busyCyc++;
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearMon();
        txQ.delete();
        rdQ.delete();
        firstRd = -1;
        firstTx = -1;
        doneCnt = 0;
        doneCyc = -1;
        busyCyc = 0;
    endtask

    task automatic pulseStart(input int len);
        @(negedge clk);
        data_length = 8'(len);
        start = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        start = 1'b0;
        data_length = 8'hEE;
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (doneCnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", (doneCnt > 0) ? 1 : 0, 1);
    endtask

    task automatic runFrame(input int len, input int lat, input int bound);
        clearMon();
        uartLat = lat;
        pulseStart(len);
        waitDone(bound);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int         len;
        logic [7:0] d [4];
        logic [7:0] csum;
    } vecT;

    vecT tbl [5];

    initial begin
        int nExp;
        int seqErr;
        logic [7:0] sum;

        tbl[0].len = 3; tbl[0].d = '{8'h11, 8'h22, 8'h33, 8'h00};
        tbl[0].csum = 8'h66;
        tbl[1].len = 0; tbl[1].d = '{8'h77, 8'h00, 8'h00, 8'h00};
        tbl[1].csum = 8'h00;
        tbl[2].len = 1; tbl[2].d = '{8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[2].csum = 8'hA5;
        tbl[3].len = 2; tbl[3].d = '{8'hF0, 8'h20, 8'h00, 8'h00};
        tbl[3].csum = 8'h10;
        tbl[4].len = 4; tbl[4].d = '{8'hFF, 8'h01, 8'h80, 8'h80};
        tbl[4].csum = 8'h00;

        for (int i = 0; i < 256; i++) mem[i] = 8'hC3;
        clearMon();

        repeat (2) @(negedge clk);
        chk("reset_outs", int'({ram_addr, ram_rd_en, tx_data, tx_valid,
                                busy, done}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = tbl[v].d[i];
            runFrame(tbl[v].len, 10, 400);
            nExp = tbl[v].len + ((CSUM && tbl[v].len > 0) ? 1 : 0);
            chk($sformatf("v%0d_count", v), txQ.size(), nExp);
            for (int i = 0; i < nExp && i < txQ.size(); i++)
                chk($sformatf("v%0d_byte%0d", v, i), int'(txQ[i]),
                    int'(i < tbl[v].len ? tbl[v].d[i] : tbl[v].csum));
            chk($sformatf("v%0d_done", v), doneCnt, 1);
            if (tbl[v].len > 0) begin
                chk($sformatf("v%0d_rd_lat", v), firstRd - startCyc, 1);
                chk($sformatf("v%0d_tx_lat", v), firstTx - startCyc, 3);
            end else begin
                chk($sformatf("v%0d_done_lat", v), doneCyc - startCyc, 2);
                chk($sformatf("v%0d_busy_cyc", v), busyCyc, 2);
            end
        end

        // second start during a 2-byte frame is ignored
        mem[0] = 8'h44; mem[1] = 8'h55; mem[2] = 8'h66; mem[3] = 8'h77;
        clearMon();
        uartLat = 10;
        pulseStart(2);
        repeat (6) @(negedge clk);
        pulseStart(4);
        waitDone(400);
        repeat (20) @(negedge clk);
        chk("restart_count", txQ.size(), 2 + (CSUM ? 1 : 0));
        chk("restart_done", doneCnt, 1);
        if (txQ.size() >= 2) begin
            chk("restart_b0", int'(txQ[0]), 'h44);
            chk("restart_b1", int'(txQ[1]), 'h55);
        end

        // abort while the first of 4 bytes is in WAIT_TX
        clearMon();
        pulseStart(4);
        begin
            int n = 0;
            while (txQ.size() == 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("abort_first_tx", txQ.size(), 1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", int'({busy, tx_valid, ram_rd_en, done}), 0);
        repeat (60) @(negedge clk);
        chk("abort_no_more_tx", txQ.size(), 1);
        chk("abort_no_done", doneCnt, 0);

        // reset while stuck in WAIT_ACK, then a fresh frame
        mem[0] = 8'h5A;
        clearMon();
        uartHold = 1'b1;
        pulseStart(1);
        repeat (4) @(negedge clk);
        chk("wa_tx_data", int'(tx_data), 'h5A);
        chk("wa_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", int'({ram_addr, ram_rd_en, tx_data,
                                         tx_valid, busy, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        uartHold = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", int'(busy), 0);
        mem[0] = 8'h31; mem[1] = 8'h32;
        runFrame(2, 10, 400);
        chk("post_reset_rd0", rdQ.size() > 0 ? int'(rdQ[0]) : -1, 0);
        chk("post_reset_count", txQ.size(), 2 + (CSUM ? 1 : 0));
        if (txQ.size() >= 2) begin
            chk("post_reset_b0", int'(txQ[0]), 'h31);
            chk("post_reset_b1", int'(txQ[1]), 'h32);
        end

        // maximum length: addresses 0..254, no index wrap
        sum = '0;
        for (int i = 0; i < 255; i++) begin
            mem[i] = 8'(i);
            sum = sum + 8'(i);
        end
        runFrame(255, 2, 6000);
        chk("max_rd_count", rdQ.size(), 255);
        chk("max_count", txQ.size(), 255 + (CSUM ? 1 : 0));
        seqErr = 0;
        for (int i = 0; i < rdQ.size() && i < 255; i++)
            if (rdQ[i] != 8'(i)) seqErr++;
        chk("max_addr_seq", seqErr, 0);
        chk("max_last_addr",
            rdQ.size() > 0 ? int'(rdQ[rdQ.size()-1]) : -1, 254);
        if (CSUM && txQ.size() == 256)
            chk("max_csum", int'(txQ[255]), int'(sum));
        chk("max_done", doneCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 Parameter ADDR_W, default 8, sets the width of the RAM address and of the frame length.
REQ-002 Port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 Port start, input, 1, one-cycle request to send a frame; sampled only in IDLE.
REQ-005 Port abort, input, 1, synchronous cancel of the frame in progress.
REQ-006 Port data_length, input, ADDR_W, number of payload bytes; latched on an accepted start.
REQ-007 Port ram_addr, output, ADDR_W, read address to the frame RAM.
REQ-008 Port ram_rd_en, output, 1, RAM read strobe.
REQ-009 Port ram_data, input, 8, RAM read data; valid exactly 1 cycle after ram_rd_en.
REQ-010 Port tx_data, output, 8, byte to the UART transmitter.
REQ-011 Port tx_valid, output, 1, one-cycle pulse that launches tx_data.
REQ-012 Port tx_busy, input, 1, UART transmitter busy flag.
REQ-013 Port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-014 Port done, output, 1, one-cycle pulse when a frame completes normally.

Function
REQ-015 The FSM SHALL have states IDLE, READ, LOAD, SEND, WAIT_ACK, WAIT_TX and FINISH.
REQ-016 In IDLE, start=1 SHALL latch data_length, clear the byte index and checksum, and go to READ, or to FINISH if the length is 0.
REQ-017 READ SHALL drive ram_rd_en=1 for one cycle with ram_addr=index, then go to LOAD.
REQ-018 LOAD SHALL register ram_data into tx_data, add it to the checksum, and go to SEND.
REQ-019 SEND SHALL pulse tx_valid for exactly one cycle, then go to WAIT_ACK.
REQ-020 WAIT_ACK SHALL stay until tx_busy=1, then go to WAIT_TX.
REQ-021 WAIT_TX SHALL stay until tx_busy=0, then increment the index and go to READ if index+1 < length, else to FINISH.
REQ-022 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-023 Latency: start at cycle N SHALL give ram_rd_en at N+1 and tx_valid at N+3.
REQ-024 A start received while busy=1 SHALL be ignored; a change of data_length mid-frame SHALL have no effect.
REQ-025 data_length=0 SHALL produce no tx_valid and a done pulse 2 cycles after start.
REQ-026 The maximum length (2^ADDR_W-1) SHALL send addresses 0 through 2^ADDR_W-2 without the index wrapping.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge, with no done pulse, tx_valid=0 and ram_rd_en=0.
REQ-028 If abort and tx_busy change in the same cycle, abort SHALL take priority.
REQ-029 The checksum SHALL be the 8-bit sum mod 256 of all bytes sent.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and set ram_addr=0, ram_rd_en=0, tx_data=0, tx_valid=0, busy=0, done=0, index=0 and checksum=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; after release the FSM SHALL wait for a new start.

Configuration
REQ-032 With UART_FRAME_CHECKSUM_EN defined, after the last payload byte WAIT_TX SHALL enter SEND with tx_data=checksum, send that one extra byte, and only then go to FINISH.
REQ-033 Without UART_FRAME_CHECKSUM_EN, the checksum register and the extra byte SHALL be absent, and the frame is exactly data_length bytes.

Structure
REQ-034 A shared package uart_flash_pkg SHALL hold the FSM state enumeration, the byte width constant (8) and the ADDR_W default.
REQ-035 The block SHALL be a single module with no sub-modules; tx_busy is used as a level, so no edge detector is needed.

Verification
REQ-036 Length 3, RAM holding {0x11,0x22,0x33}, UART model busy for 10 cycles per byte -> tx_data 0x11, 0x22, 0x33 in order, one tx_valid each, one done.
REQ-037 Length 0 -> no tx_valid; done 2 cycles after start; busy high for exactly 2 cycles.
REQ-038 Start pulsed again during a length-2 frame -> exactly 2 bytes sent and one done.
REQ-039 abort while in WAIT_TX of byte 1 of 4 -> IDLE next cycle, no further tx_valid, no done.
REQ-040 UART_FRAME_CHECKSUM_EN defined, bytes {0xF0,0x20} -> 3 bytes sent: 0xF0, 0x20, 0x10.
REQ-041 rst_n low during WAIT_ACK -> all outputs 0 asynchronously; a new start after release sends from address 0.
